fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 24 ++
 rtl/fetch_stage_pc_next_sel.sv | 19 +
 rtl/fetch_stage.sv | 89 ++++++++
 tb/tb_fetch_stage.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the instruction fetch stage.
// Also holds the stop_f encodings and the fetch FSM states.
package fetch_stage_pkg;

  localparam logic [31:0] NOP     = 32'hdc000000;
  localparam logic [5:0]  HALT_OP = 6'h3f;

  typedef enum logic [1:0] {
    END    = 2'b00,
    VALID  = 2'b01,
    BUBBLE = 2'b10
  } stop_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } state_e;

  function automatic logic is_halt(input logic [31:0] ins);
    return ins[31:26] == HALT_OP;
  endfunction

endpackage

// File: rtl/fetch_stage_pc_next_sel.sv
// Next fetch address select while running.
// Priority: redirect, then hold on stall, then sequential.
module pc_next_sel (
  input  logic [31:0] pc_q,
  input  logic        stall_d,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic [31:0] npc_o
);

  always_comb begin
    npc_o = pc_q + 32'd4;
    if (br_taken)
      npc_o = br_target;
    else if (stall_d)
      npc_o = pc_q;
  end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: drives a synchronous imem and presents
// one instruction per cycle with stall, redirect and halt.
module fetch_stage
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rstd,
  input  logic        stall_d,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] ins_out,
  output logic [1:0]  stop_f,
  output logic [31:0] icount
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] icount_q, icount_d;
  logic [31:0] npc;
  stop_e       sf;
  logic [31:0] ins;

  pc_next_sel u_sel (
    .pc_q      (pc_q),
    .stall_d   (stall_d),
    .br_taken  (br_taken),
    .br_target (br_target),
    .npc_o     (npc)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    icount_d = icount_q;
    sf       = BUBBLE;
    ins      = NOP;
    unique case (state_q)
      IDLE: begin
        pc_d    = br_taken ? br_target : pc_q;
        state_d = br_taken ? IDLE : RUN;
      end
      RUN: begin
        ins  = imem_rdata;
        pc_d = npc;
        if (br_taken) begin
          sf = BUBBLE;
        end else if (stall_d) begin
          sf = VALID;
        end else if (is_halt(imem_rdata)) begin
          // park on the halt word so address stays frozen
          sf      = END;
          pc_d    = pc_q;
          state_d = HALT;
        end else begin
          sf       = VALID;
          icount_d = icount_q + 32'd1;
        end
      end
      HALT: begin
        sf = END;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      icount_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      icount_q <= icount_d;
    end
  end

  assign imem_addr = rstd ? pc_d : 32'd0;
  assign pc_out    = pc_q;
  assign ins_out   = ins;
  assign stop_f    = sf;
  assign icount    = icount_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a synchronous
// instruction memory model.
module tb_fetch_stage;

  localparam logic [31:0] NOPW  = 32'hdc000000;
  localparam logic [31:0] HALTW = 32'hfc000000;

  logic        clk = 1'b0;
  logic        rstd;
  logic        stall_d;
  logic        br_taken;
  logic [31:0] br_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] pc_out;
  logic [31:0] ins_out;
  logic [1:0]  stop_f;
  logic [31:0] icount;

  int total = 0;
  int bad   = 0;

  fetch_stage dut (
    .clk        (clk),
    .rstd       (rstd),
    .stall_d    (stall_d),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .pc_out     (pc_out),
    .ins_out    (ins_out),
    .stop_f     (stop_f),
    .icount     (icount)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    if (a == 32'h14) return HALTW;
    return 32'h13000000 | {8'h00, a[23:0]};
  endfunction

  always @(posedge clk) imem_rdata <= word(imem_addr);

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic cv(input string tag, input logic [1:0] sf,
                    input logic [31:0] pc, input logic [31:0] ins);
    chk({tag, ".stop"}, {30'd0, stop_f}, {30'd0, sf});
    chk({tag, ".pc"}, pc_out, pc);
    chk({tag, ".ins"}, ins_out, ins);
  endtask

  task automatic step(input logic s, input logic b,
                      input logic [31:0] t);
    @(posedge clk);
    #2;
    stall_d   = s;
    br_taken  = b;
    br_target = t;
    #1;
  endtask

  task automatic do_reset();
    stall_d   = 1'b0;
    br_taken  = 1'b0;
    br_target = 32'd0;
    rstd      = 1'b0;
    #1;
    cv("rst", 2'b10, 32'd0, NOPW);
    chk("rst.cnt", icount, 32'd0);
    chk("rst.addr", imem_addr, 32'd0);
    @(negedge clk);
    rstd = 1'b1;
    #1;
  endtask

  initial begin
    rstd      = 1'b1;
    stall_d   = 1'b0;
    br_taken  = 1'b0;
    br_target = 32'd0;
    #1;
    do_reset();
    chk("idle.stop", {30'd0, stop_f}, 32'd2);
    chk("idle.addr", imem_addr, 32'd0);

    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 32'd0);
      cv("seq", 2'b01, 32'(i * 4), word(32'(i * 4)));
    end

    step(1'b0, 1'b1, 32'h100);
    chk("seq.cnt4", icount, 32'd4);
    cv("br", 2'b10, 32'h10, word(32'h10));
    chk("br.addr", imem_addr, 32'h100);
    step(1'b0, 1'b0, 32'd0);
    cv("br.tgt", 2'b01, 32'h100, word(32'h100));
    chk("br.addr2", imem_addr, 32'h104);

    step(1'b0, 1'b1, 32'd8);
    chk("br8.cnt", icount, 32'd5);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 32'd0);
      cv("stall", 2'b01, 32'd8, word(32'd8));
      chk("stall.addr", imem_addr, 32'd8);
      chk("stall.cnt", icount, 32'd5);
    end
    step(1'b0, 1'b0, 32'd0);
    cv("rel", 2'b01, 32'd8, word(32'd8));
    chk("rel.addr", imem_addr, 32'd12);
    step(1'b0, 1'b0, 32'd0);
    cv("after", 2'b01, 32'd12, word(32'd12));
    chk("after.cnt", icount, 32'd6);
    step(1'b0, 1'b0, 32'd0);
    chk("pre.cnt", icount, 32'd7);

    step(1'b0, 1'b0, 32'd0);
    cv("hlt", 2'b00, 32'h14, HALTW);
    chk("hlt.cnt", icount, 32'd8);
    for (int i = 0; i < 10; i++) begin
      step(1'(i), 1'(i >> 1), 32'h200);
      cv("halt", 2'b00, 32'h14, NOPW);
      chk("halt.addr", imem_addr, 32'h14);
      chk("halt.cnt", icount, 32'd8);
    end

    do_reset();
    chk("r2.stop", {30'd0, stop_f}, 32'd2);
    step(1'b0, 1'b1, 32'h14);
    cv("r2.c2", 2'b10, 32'd0, word(32'd0));
    step(1'b0, 1'b1, 32'h40);
    cv("hbr", 2'b10, 32'h14, HALTW);
    chk("hbr.addr", imem_addr, 32'h40);
    step(1'b0, 1'b0, 32'd0);
    cv("hbr.tgt", 2'b01, 32'h40, word(32'h40));
    step(1'b0, 1'b1, 32'h14);
    cv("br14", 2'b10, 32'h44, word(32'h44));
    step(1'b1, 1'b0, 32'd0);
    cv("hst", 2'b01, 32'h14, HALTW);
    chk("hst.addr", imem_addr, 32'h14);
    step(1'b0, 1'b0, 32'd0);
    cv("hrel", 2'b00, 32'h14, HALTW);
    step(1'b0, 1'b0, 32'd0);
    cv("hrel.h", 2'b00, 32'h14, NOPW);
    chk("hrel.cnt", icount, 32'd1);

    do_reset();
    br_taken  = 1'b1;
    br_target = 32'hfffffffc;
    #1;
    chk("ibr.stop", {30'd0, stop_f}, 32'd2);
    chk("ibr.addr", imem_addr, 32'hfffffffc);
    step(1'b0, 1'b0, 32'd0);
    cv("ibr.idle", 2'b10, 32'hfffffffc, NOPW);
    chk("ibr.addr2", imem_addr, 32'hfffffffc);
    step(1'b0, 1'b0, 32'd0);
    cv("wrap", 2'b01, 32'hfffffffc, word(32'hfffffffc));
    chk("wrap.addr", imem_addr, 32'd0);
    step(1'b0, 1'b0, 32'd0);
    cv("wrap0", 2'b01, 32'd0, word(32'd0));
    chk("wrap.cnt", icount, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
